if_fetch_stage: RTL and testbench

Instruction fetch stage. It is the producer end of the fetch-to-decode interface: it owns the PC, issues one-outstanding-request reads to the instruction memory/cache, and presents {pc, instruction} with a valid flag to the decode stage. It honours the downstream stall, and handles branch/jump redirects with correct squashing of in-flight responses.

---
 rtl/if_fetch_stage.sv | 184 ++++++++++++++++++
 tb/tb_if_fetch_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction fetch stage: producer end of the fetch-to-decode interface.
// Owns the PC, issues single-outstanding reads to instruction memory and
// presents {if_pc, if_instruction} with if_valid to decode. Honours the decode
// stall and squashes in-flight responses across branch/jump redirects.
//
// Optional build macro: IF_PERF_CNT_EN adds perf_fetch_cnt (transfers to
// decode) and perf_imem_wait_cnt (cycles waiting on memory).
//
// Ports:
//   clk                 clock
//   rst                 synchronous active-high reset
//   stall_i             decode cannot accept this cycle
//   redirect            control-flow change from a later stage
//   redirect_pc[31:0]   target PC when redirect=1
//   imem_address[31:0]  instruction memory address
//   imem_read           read request
//   imem_resp           read data valid; completes the request
//   imem_rdata[31:0]    instruction word
//   if_valid            if_pc/if_instruction hold a live instruction
//   if_pc[31:0]         PC of presented instruction
//   if_instruction[31:0] presented instruction word
//   perf_fetch_cnt[31:0], perf_imem_wait_cnt[31:0]   (IF_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_address,
   output logic        imem_read,
   input  logic        imem_resp,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instruction
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_imem_wait_cnt
`endif
);

   // FETCH: request at pc in flight, nothing presented.
   // VALID: buffer presented; next request at pc overlaps with the transfer.
   // KILL : an orphaned request at req_addr must finish before pc is fetched.
   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_VALID = 2'd1,
      S_KILL  = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_req_addr;
   logic [31:0] r_if_pc;
   logic [31:0] r_if_instr;

   state_t      w_state_nxt;
   logic [31:0] w_pc_nxt;
   logic [31:0] w_req_addr_nxt;
   logic        w_load;

   // NOTE: every signal driven here gets a default first so no path leaves it
   // unassigned; a missing default would infer a latch.
   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_req_addr_nxt = r_req_addr;
      w_load         = 1'b0;
      case (r_state)
         S_FETCH: begin
            if (imem_resp) begin
               if (redirect) begin
                  // Response belongs to the old path: drop it, restart at target.
                  w_pc_nxt = redirect_pc;
               end else begin
                  w_load      = 1'b1;
                  w_pc_nxt    = r_pc + 32'd4;
                  w_state_nxt = S_VALID;
               end
            end else if (redirect) begin
               // Memory still owes us this request; remember where it went.
               w_req_addr_nxt = r_pc;
               w_pc_nxt       = redirect_pc;
               w_state_nxt    = S_KILL;
            end
         end
         S_VALID: begin
            if (redirect) begin
               w_pc_nxt    = redirect_pc;
               w_state_nxt = S_FETCH;
            end else if (!stall_i) begin
               if (imem_resp) begin
                  w_load   = 1'b1;
                  w_pc_nxt = r_pc + 32'd4;
               end else begin
                  w_state_nxt = S_FETCH;
               end
            end
         end
         S_KILL: begin
            if (redirect) begin
               w_pc_nxt = redirect_pc;
            end
            if (imem_resp) begin
               w_state_nxt = S_FETCH;
            end
         end
         default: begin
            w_state_nxt = S_FETCH;
         end
      endcase
   end

   // Memory-side outputs. While VALID and stalled (or redirected) no new
   // request is issued, so the address is free to follow pc.
   always_comb begin
      imem_read    = 1'b0;
      imem_address = (r_state == S_KILL) ? r_req_addr : r_pc;
      if (!rst) begin
         case (r_state)
            S_FETCH: imem_read = 1'b1;
            S_KILL:  imem_read = 1'b1;
            S_VALID: imem_read = !stall_i && !redirect;
            default: imem_read = 1'b0;
         endcase
      end
   end

   // NOTE: state lives in always_ff with non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   // NOTE: the presentation buffer is reset too, since if_pc/if_instruction
   // are visible outputs with defined reset values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_FETCH;
         r_pc       <= RESET_PC;
         r_req_addr <= 32'd0;
         r_if_pc    <= 32'd0;
         r_if_instr <= 32'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_req_addr <= w_req_addr_nxt;
         if (w_load) begin
            r_if_pc    <= r_pc;
            r_if_instr <= imem_rdata;
         end
      end
   end

   assign if_valid       = (r_state == S_VALID);
   assign if_pc          = r_if_pc;
   assign if_instruction = r_if_instr;

`ifdef IF_PERF_CNT_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_wait_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_cnt <= 32'd0;
         r_wait_cnt  <= 32'd0;
      end else begin
         if (if_valid && !stall_i) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
         end
         if (imem_read && !imem_resp) begin
            r_wait_cnt <= r_wait_cnt + 32'd1;
         end
      end
   end

   assign perf_fetch_cnt     = r_fetch_cnt;
   assign perf_imem_wait_cnt = r_wait_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Self-checking bench for if_fetch_stage. A stimulus task drives one cycle at
// a time and plays the instruction memory; a program-order reference model
// (next fetch PC, squash flag, queue of expected deliveries) pushes expected
// instructions, and an independent monitor pops and compares them on every
// transfer to decode.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0060;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_i = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic [31:0] imem_address;
   logic        imem_read;
   logic        imem_resp = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instruction;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_imem_wait_cnt;
`endif

   if_fetch_stage #(.RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall_i        (stall_i),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .imem_address   (imem_address),
      .imem_read      (imem_read),
      .imem_resp      (imem_resp),
      .imem_rdata     (imem_rdata),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instruction (if_instruction)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_fetch_cnt     (perf_fetch_cnt),
      .perf_imem_wait_cnt (perf_imem_wait_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_t;

   // Reference model state
   fetch_t      exp_q[$];          // accepted, not yet delivered or squashed
   logic [31:0] m_pc = RESET_PC;   // next program-order fetch address
   bit          m_tainted = 1'b0;  // outstanding request predates a redirect
   bit          m_pending = 1'b0;  // request open from previous cycle
   logic [31:0] m_pend_addr = 32'd0;
   logic [31:0] m_fetch_cnt = 32'd0;
   logic [31:0] m_wait_cnt = 32'd0;
   bit          run_mon = 1'b0;

   // Monitor: 2 time units after the driving edge, inputs settled, before any
   // model update of this cycle.
   always @(negedge clk) begin
      fetch_t e;
      #2;
      if (run_mon) begin
         check("valid_vs_model", if_valid, exp_q.size() != 0);
         if (if_valid && !stall_i && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("xfer_pc", if_pc, e.pc);
            check("xfer_instr", if_instruction, e.instr);
         end
`ifdef IF_PERF_CNT_EN
         check("perf_fetch", perf_fetch_cnt, m_fetch_cnt);
         check("perf_wait", perf_imem_wait_cnt, m_wait_cnt);
`endif
      end
   end

   // One clock cycle of stimulus plus memory behaviour plus model update.
   // resp_mode: 0 never respond, 1 respond whenever asked, 2 random latency.
   task automatic cycle(input bit r, input bit st, input bit rd,
                        input logic [31:0] rpc, input int resp_mode);
      @(negedge clk);
      rst         = r;
      stall_i     = st;
      redirect    = rd;
      redirect_pc = rpc;
      imem_resp   = 1'b0;
      #1;
      case (resp_mode)
         0:       imem_resp = 1'b0;
         1:       imem_resp = imem_read;
         default: imem_resp = imem_read && ($urandom_range(0, 2) != 0);
      endcase
      imem_rdata = imem_resp ? mem_word(imem_address) : $urandom;
      // A request is expected unless reset or a presented instruction is held.
      check("read_expected", imem_read, !r && !(exp_q.size() != 0 && (st || rd)));
      if (!r && m_pending) check("addr_stable", imem_address, m_pend_addr);
      if (imem_read && !m_tainted) check("fetch_addr", imem_address, m_pc);
      #2;
      if (if_valid && !stall_i) m_fetch_cnt++;
      if (imem_read && !imem_resp) m_wait_cnt++;
      if (r) begin
         exp_q.delete();
         m_pc        = RESET_PC;
         m_tainted   = 1'b0;
         m_pending   = 1'b0;
         m_fetch_cnt = 32'd0;
         m_wait_cnt  = 32'd0;
      end else begin
         if (imem_read && imem_resp) begin
            if (!m_tainted && !rd) begin
               exp_q.push_back(fetch_t'({m_pc, mem_word(m_pc)}));
               m_pc = m_pc + 32'd4;
            end
            m_tainted = 1'b0;
         end
         if (rd) begin
            exp_q.delete();
            m_pc = rpc;
            if (imem_read && !imem_resp) m_tainted = 1'b1;
         end
         m_pending   = imem_read && !imem_resp;
         m_pend_addr = imem_address;
      end
   endtask

   initial begin
      bit          r, st, rd;
      logic [31:0] rpc;

      // Reset
      cycle(1, 0, 0, 32'd0, 1);
      run_mon = 1'b1;
      cycle(1, 0, 0, 32'd0, 1);
      check("rst_read", imem_read, 0);

      // Back-to-back hits from RESET_PC
      cycle(0, 0, 0, 32'd0, 1);
      check("rst_valid", if_valid, 0);
      check("rst_if_pc", if_pc, 32'd0);
      check("rst_if_instr", if_instruction, 32'd0);
      check("first_addr", imem_address, 32'h60);
      for (int i = 1; i <= 5; i++) begin
         cycle(0, 0, 0, 32'd0, 1);
         check("seq_addr", imem_address, 32'h60 + 32'(4 * i));
         check("seq_valid", if_valid, 1);
         check("seq_pc", if_pc, 32'h60 + 32'(4 * (i - 1)));
      end

      // Stall: presented 0x74 must hold, no requests issued
      for (int i = 0; i < 3; i++) begin
         cycle(0, 1, 0, 32'd0, 1);
         check("stall_read", imem_read, 0);
         check("stall_pc", if_pc, 32'h74);
         check("stall_instr", if_instruction, 32'hA5A5_0074);
      end
      cycle(0, 0, 0, 32'd0, 1);
      check("release_addr", imem_address, 32'h78);

      // Redirect during an outstanding miss
      cycle(0, 0, 1, 32'h70, 0);
      cycle(0, 0, 0, 32'd0, 0);
      check("miss_addr", imem_address, 32'h70);
      cycle(0, 0, 1, 32'h200, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 0, 32'd0, 0);
         check("kill_addr", imem_address, 32'h70);
         check("kill_valid", if_valid, 0);
      end
      cycle(0, 0, 0, 32'd0, 1);
      check("kill_resp_addr", imem_address, 32'h70);
      cycle(0, 0, 0, 32'd0, 0);
      check("after_kill_addr", imem_address, 32'h200);
      check("after_kill_valid", if_valid, 0);

      // Redirect with response in the same FETCH cycle
      cycle(0, 0, 1, 32'h300, 1);
      cycle(0, 0, 0, 32'd0, 0);
      check("same_cycle_addr", imem_address, 32'h300);
      check("same_cycle_valid", if_valid, 0);

      // Redirect while VALID and stalled
      cycle(0, 0, 1, 32'h80, 1);
      cycle(0, 0, 0, 32'd0, 1);
      cycle(0, 1, 1, 32'h400, 1);
      check("vs_pc", if_pc, 32'h80);
      cycle(0, 0, 0, 32'd0, 0);
      check("vs_valid", if_valid, 0);
      check("vs_addr", imem_address, 32'h400);

      // Reset in the middle of a miss at 0x90
      cycle(0, 0, 1, 32'h90, 0);
      cycle(0, 0, 0, 32'd0, 1);
      cycle(0, 0, 0, 32'd0, 0);
      check("pre_rst_addr", imem_address, 32'h90);
      cycle(1, 0, 0, 32'd0, 1);
      check("mid_rst_read", imem_read, 0);
      cycle(0, 0, 0, 32'd0, 0);
      check("post_rst_addr", imem_address, 32'h60);
      check("post_rst_valid", if_valid, 0);
`ifdef IF_PERF_CNT_EN
      check("post_rst_fetch_cnt", perf_fetch_cnt, 32'd0);
      check("post_rst_wait_cnt", perf_imem_wait_cnt, 32'd0);
`endif

      // PC wraps modulo 2^32
      cycle(0, 0, 1, 32'hFFFF_FFF8, 1);
      for (int i = 0; i < 4; i++) begin
         cycle(0, 0, 0, 32'd0, 1);
         check("wrap_addr", imem_address, 32'hFFFF_FFF8 + 32'(4 * i));
      end

      // Randomized traffic
      for (int n = 0; n < 4000; n++) begin
         r   = ($urandom_range(0, 199) == 0);
         st  = ($urandom_range(0, 3) == 0);
         rd  = ($urandom_range(0, 9) == 0);
         rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                           : $urandom;
         cycle(r, st, rd, rpc, 2);
      end
      cycle(0, 0, 0, 32'd0, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
